// File: rtl/display_modes_pkg.sv
// Video mode definitions shared by the multimode timing generator: mode indices,
// the per-mode timing record, the built-in mode table and blanking-start helpers.
package display_modes_pkg;

    localparam int TW = 12;

    localparam logic [1:0] MODE_640X480   = 2'd0;
    localparam logic [1:0] MODE_800X600   = 2'd1;
    localparam logic [1:0] MODE_1280X720  = 2'd2;
    localparam logic [1:0] MODE_1920X1080 = 2'd3;

    typedef struct packed {
        logic [TW-1:0] h_res;
        logic [TW-1:0] h_fp;
        logic [TW-1:0] h_sync;
        logic [TW-1:0] h_bp;
        logic [TW-1:0] v_res;
        logic [TW-1:0] v_fp;
        logic [TW-1:0] v_sync;
        logic [TW-1:0] v_bp;
        logic          h_pol;
        logic          v_pol;
    } timing_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_PEND = 1'b1
    } req_state_t;

    localparam timing_t T_640X480 = '{
        h_res: 12'd640,  h_fp: 12'd16,  h_sync: 12'd96, h_bp: 12'd48,
        v_res: 12'd480,  v_fp: 12'd10,  v_sync: 12'd2,  v_bp: 12'd33,
        h_pol: 1'b0, v_pol: 1'b0};

    localparam timing_t T_800X600 = '{
        h_res: 12'd800,  h_fp: 12'd40,  h_sync: 12'd128, h_bp: 12'd88,
        v_res: 12'd600,  v_fp: 12'd1,   v_sync: 12'd4,   v_bp: 12'd23,
        h_pol: 1'b1, v_pol: 1'b1};

    localparam timing_t T_1280X720 = '{
        h_res: 12'd1280, h_fp: 12'd110, h_sync: 12'd40, h_bp: 12'd220,
        v_res: 12'd720,  v_fp: 12'd5,   v_sync: 12'd5,  v_bp: 12'd20,
        h_pol: 1'b1, v_pol: 1'b1};

    localparam timing_t T_1920X1080 = '{
        h_res: 12'd1920, h_fp: 12'd88,  h_sync: 12'd44, h_bp: 12'd148,
        v_res: 12'd1080, v_fp: 12'd4,   v_sync: 12'd5,  v_bp: 12'd36,
        h_pol: 1'b1, v_pol: 1'b1};

    // Blanking precedes active video, so the start coordinate is negative.
    function automatic int h_sta(input timing_t t);
        return -(int'(t.h_fp) + int'(t.h_sync) + int'(t.h_bp));
    endfunction

    function automatic int v_sta(input timing_t t);
        return -(int'(t.v_fp) + int'(t.v_sync) + int'(t.v_bp));
    endfunction

endpackage

// File: rtl/display_mode_rom.sv
// Combinational lookup from a mode index to its timing record.
module display_mode_rom
    import display_modes_pkg::*;
(
    input  logic [1:0] i_mode,
    output timing_t    o_timing
);

    always_comb begin
        o_timing = T_800X600;
        case (i_mode)
            MODE_640X480:   o_timing = T_640X480;
            MODE_800X600:   o_timing = T_800X600;
            MODE_1280X720:  o_timing = T_1280X720;
            MODE_1920X1080: o_timing = T_1920X1080;
            default:        o_timing = T_800X600;
        endcase
    end

endmodule

// File: rtl/display_timings_multimode.sv
// Runtime-switchable video timing generator; mode requests are queued through a
// two-state handshake and take effect only at the frame wrap.
module display_timings_multimode
    import display_modes_pkg::*;
#(
    parameter int CORDW        = 16,
    parameter int DEFAULT_MODE = 1
) (
    input  logic                    i_pix_clk,
    input  logic                    i_rst,
    input  logic [1:0]              i_mode_sel,
    input  logic                    i_mode_valid,
    output logic                    o_mode_busy,
    output logic                    o_mode_ack,
    output logic [1:0]              o_mode,
    output logic                    o_hs,
    output logic                    o_vs,
    output logic                    o_de,
    output logic                    o_frame,
    output logic                    o_line,
    output logic signed [CORDW-1:0] o_sx,
    output logic signed [CORDW-1:0] o_sy
);

    localparam logic [1:0]              DEF_MODE = 2'(DEFAULT_MODE);
    localparam logic signed [CORDW-1:0] C_ONE    = CORDW'(1);

    req_state_t r_state;
    req_state_t w_state_next;
    logic       w_capture;
    logic       w_apply;
    logic       w_line_end;
    logic       w_frame_end;

    logic [1:0] w_rom_sel;
    timing_t    w_rom_timing;
    timing_t    r_timing;
    timing_t    r_pend_timing;
    timing_t    w_timing_next;
    logic [1:0] r_mode;
    logic [1:0] r_pend_mode;
    logic       r_run;

    logic signed [CORDW-1:0] r_sx;
    logic signed [CORDW-1:0] r_sy;
    logic signed [CORDW-1:0] w_sx_next;
    logic signed [CORDW-1:0] w_sy_next;
    logic signed [CORDW-1:0] w_h_end;
    logic signed [CORDW-1:0] w_v_end;
    logic signed [CORDW-1:0] w_n_h_sta;
    logic signed [CORDW-1:0] w_n_v_sta;
    logic signed [CORDW-1:0] w_n_hs_beg;
    logic signed [CORDW-1:0] w_n_hs_end;
    logic signed [CORDW-1:0] w_n_vs_beg;
    logic signed [CORDW-1:0] w_n_vs_end;
    logic                    w_hs_act;
    logic                    w_vs_act;

    logic r_hs;
    logic r_vs;
    logic r_de;
    logic r_frame;
    logic r_line;
    logic r_ack;

    // During reset the ROM serves the default mode; otherwise it serves the
    // incoming request so the pending record is ready the cycle after capture.
    assign w_rom_sel = i_rst ? DEF_MODE : i_mode_sel;

    display_mode_rom u_rom (
        .i_mode   (w_rom_sel),
        .o_timing (w_rom_timing)
    );

    assign w_line_end  = r_run && (r_sx == w_h_end);
    assign w_frame_end = w_line_end && (r_sy == w_v_end);

    always_comb begin
        w_state_next = r_state;
        w_capture    = 1'b0;
        w_apply      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_mode_valid) begin
                    w_state_next = ST_PEND;
                    w_capture    = 1'b1;
                end
            end
            ST_PEND: begin
                if (w_frame_end) begin
                    w_state_next = ST_IDLE;
                    w_apply      = 1'b1;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Everything registered below describes the coordinate being loaded, so it
    // is derived from the timing record that will be in force next cycle.
    assign w_timing_next = w_apply ? r_pend_timing : r_timing;

    assign w_h_end    = CORDW'(int'(r_timing.h_res) - 1);
    assign w_v_end    = CORDW'(int'(r_timing.v_res) - 1);
    assign w_n_h_sta  = CORDW'(h_sta(w_timing_next));
    assign w_n_v_sta  = CORDW'(v_sta(w_timing_next));
    assign w_n_hs_beg = CORDW'(h_sta(w_timing_next) + int'(w_timing_next.h_fp));
    assign w_n_hs_end = CORDW'(h_sta(w_timing_next) + int'(w_timing_next.h_fp)
                               + int'(w_timing_next.h_sync));
    assign w_n_vs_beg = CORDW'(v_sta(w_timing_next) + int'(w_timing_next.v_fp));
    assign w_n_vs_end = CORDW'(v_sta(w_timing_next) + int'(w_timing_next.v_fp)
                               + int'(w_timing_next.v_sync));

    // The first cycle after reset holds at the start so it shows the frame strobe.
    always_comb begin
        w_sx_next = r_sx;
        w_sy_next = r_sy;
        if (r_run) begin
            if (w_line_end) begin
                w_sx_next = w_n_h_sta;
                w_sy_next = (r_sy == w_v_end) ? w_n_v_sta : r_sy + C_ONE;
            end else begin
                w_sx_next = r_sx + C_ONE;
            end
        end
    end

    assign w_hs_act = (w_sx_next >= w_n_hs_beg) && (w_sx_next < w_n_hs_end);
    assign w_vs_act = (w_sy_next >= w_n_vs_beg) && (w_sy_next < w_n_vs_end);

    always_ff @(posedge i_pix_clk) begin
        if (i_rst) begin
            r_state       <= ST_IDLE;
            r_run         <= 1'b0;
            r_mode        <= DEF_MODE;
            r_timing      <= w_rom_timing;
            r_pend_mode   <= '0;
            r_pend_timing <= '0;
        end else begin
            r_state  <= w_state_next;
            r_run    <= 1'b1;
            r_timing <= w_timing_next;
            if (w_capture) begin
                r_pend_mode   <= i_mode_sel;
                r_pend_timing <= w_rom_timing;
            end
            if (w_apply) begin
                r_mode <= r_pend_mode;
            end
        end
    end

    always_ff @(posedge i_pix_clk) begin
        if (i_rst) begin
            r_sx    <= CORDW'(h_sta(w_rom_timing));
            r_sy    <= CORDW'(v_sta(w_rom_timing));
            r_hs    <= ~w_rom_timing.h_pol;
            r_vs    <= ~w_rom_timing.v_pol;
            r_de    <= 1'b0;
            r_frame <= 1'b0;
            r_line  <= 1'b0;
            r_ack   <= 1'b0;
        end else begin
            r_sx    <= w_sx_next;
            r_sy    <= w_sy_next;
            r_hs    <= w_hs_act ? w_timing_next.h_pol : ~w_timing_next.h_pol;
            r_vs    <= w_vs_act ? w_timing_next.v_pol : ~w_timing_next.v_pol;
            r_de    <= ~w_sx_next[CORDW-1] & ~w_sy_next[CORDW-1];
            r_frame <= (w_sx_next == w_n_h_sta) && (w_sy_next == w_n_v_sta);
            r_line  <= (w_sx_next == w_n_h_sta);
            r_ack   <= w_apply;
        end
    end

    assign o_mode_busy = (r_state == ST_PEND);
    assign o_mode_ack  = r_ack;
    assign o_mode      = r_mode;
    assign o_hs        = r_hs;
    assign o_vs        = r_vs;
    assign o_de        = r_de;
    assign o_frame     = r_frame;
    assign o_line      = r_line;
    assign o_sx        = r_sx;
    assign o_sy        = r_sy;

endmodule

// File: tb/tb_display_timings_multimode.sv
// Scoreboard bench for the multimode timing generator: frame-start records are
// queued by the stimulus and checked by an independent monitor on o_frame.
module tb_display_timings_multimode;

    localparam int CORDW = 16;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    valid;
    logic [1:0]              sel;
    logic                    busy;
    logic                    ack;
    logic [1:0]              mode;
    logic                    hs;
    logic                    vs;
    logic                    de;
    logic                    frame;
    logic                    line;
    logic signed [CORDW-1:0] sx;
    logic signed [CORDW-1:0] sy;
    logic signed [CORDW-1:0] jump_val;

    typedef struct {
        int mode;
        int sx;
        int sy;
        int ack;
        int busy;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   ack_seen = 0;

    display_timings_multimode #(
        .CORDW        (CORDW),
        .DEFAULT_MODE (1)
    ) dut (
        .i_pix_clk    (clk),
        .i_rst        (rst),
        .i_mode_sel   (sel),
        .i_mode_valid (valid),
        .o_mode_busy  (busy),
        .o_mode_ack   (ack),
        .o_mode       (mode),
        .o_hs         (hs),
        .o_vs         (vs),
        .o_de         (de),
        .o_frame      (frame),
        .o_line       (line),
        .o_sx         (sx),
        .o_sy         (sy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic expect_frame(input int m, input int x, input int y, input int a, input int b);
        exp_t e;
        e.mode = m;
        e.sx   = x;
        e.sy   = y;
        e.ack  = a;
        e.busy = b;
        exp_q.push_back(e);
    endtask

    // Overrides the row counter across one clock edge; call away from a line end.
    task automatic jump_sy(input int v);
        @(posedge clk); #2;
        jump_val = CORDW'(v);
        force dut.r_sy = jump_val;
        @(posedge clk); #2;
        release dut.r_sy;
    endtask

    task automatic wait_frame(input int bound, input string tag,
                              output int last_sx, output int last_sy, output int busy_held);
        int n;
        n         = 0;
        busy_held = 1;
        last_sx   = 0;
        last_sy   = 0;
        while (n < bound) begin
            last_sx = int'(sx);
            last_sy = int'(sy);
            if (!busy) busy_held = 0;
            @(posedge clk); #1;
            n++;
            if (frame) break;
        end
        if (!frame) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s_timeout: got no frame strobe in %0d cycles, expected one", tag, bound);
        end
    endtask

    task automatic pulse_request(input logic [1:0] m);
        @(negedge clk);
        valid = 1'b1;
        sel   = m;
        @(negedge clk);
        valid = 1'b0;
    endtask

    // Monitor: every frame strobe is one transaction against the queue head.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (ack) begin
                ack_seen++;
                check("ack_with_frame", int'(frame), 1);
            end
            if (frame) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL frame_unexpected: got frame at sx=%0d sy=%0d, expected none", sx, sy);
                end else begin
                    e = exp_q.pop_front();
                    $display("frame: mode=%0d sx=%0d sy=%0d ack=%0b busy=%0b", mode, sx, sy, ack, busy);
                    check("frame_mode", int'(mode), e.mode);
                    check("frame_sx", int'(sx), e.sx);
                    check("frame_sy", int'(sy), e.sy);
                    check("frame_ack", int'(ack), e.ack);
                    check("frame_busy", int'(busy), e.busy);
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no end of test, expected completion");
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int n, cyc, lsx, lsy, bh;
        int prev_hs, rise_sx, fall_sx, vs_min, vs_max, line1, line2;

        rst   = 1'b1;
        valid = 1'b0;
        sel   = 2'd0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_mode", int'(mode), 1);
        check("rst_sx", int'(sx), -256);
        check("rst_sy", int'(sy), -28);
        check("rst_frame", int'(frame), 0);
        check("rst_line", int'(line), 0);
        check("rst_de", int'(de), 0);
        check("rst_hs", int'(hs), 0);
        check("rst_vs", int'(vs), 0);
        check("rst_ack", int'(ack), 0);
        check("rst_busy", int'(busy), 0);

        // Release: first cycle sits at the frame start.
        expect_frame(1, -256, -28, 0, 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        check("rel_sx", int'(sx), -256);
        check("rel_sy", int'(sy), -28);
        check("rel_line", int'(line), 1);
        check("rel_hs", int'(hs), 0);

        // Mode 1 blanking lines: hs edges, vs span, line period.
        prev_hs = int'(hs);
        rise_sx = 9999; fall_sx = 9999;
        vs_min  = 9999; vs_max = -9999;
        line1   = -1;   line2 = -1;
        cyc     = 0;
        while (int'(sy) != -22 && cyc < 8000) begin
            @(posedge clk); #1;
            cyc++;
            if (!prev_hs && hs && rise_sx == 9999) rise_sx = int'(sx);
            if (prev_hs && !hs && rise_sx != 9999 && fall_sx == 9999) fall_sx = int'(sx);
            prev_hs = int'(hs);
            if (vs) begin
                if (int'(sy) < vs_min) vs_min = int'(sy);
                if (int'(sy) > vs_max) vs_max = int'(sy);
            end
            if (line) begin
                if (line1 < 0) line1 = cyc;
                else if (line2 < 0) line2 = cyc;
            end
        end
        check("m1_hs_rise_sx", rise_sx, -216);
        check("m1_hs_fall_sx", fall_sx, -88);
        check("m1_vs_first_sy", vs_min, -27);
        check("m1_vs_last_sy", vs_max, -24);
        check("m1_line_period", line2 - line1, 1056);

        // Active video starts at (0,0).
        jump_sy(-1);
        n = 0;
        while (!de && n < 3000) begin
            @(posedge clk); #1;
            n++;
        end
        check("de_rise_sx", int'(sx), 0);
        check("de_rise_sy", int'(sy), 0);

        // Mode 1 frame wrap with nothing pending.
        expect_frame(1, -256, -28, 0, 0);
        jump_sy(599);
        wait_frame(2200, "m1_wrap", lsx, lsy, bh);
        check("m1_last_sx", lsx, 799);
        check("m1_last_sy", lsy, 599);

        // Request mode 0 at row 100, then a mode 3 request while busy.
        jump_sy(100);
        pulse_request(2'd0);
        #1;
        check("req0_busy", int'(busy), 1);
        pulse_request(2'd3);
        expect_frame(0, -160, -45, 1, 0);
        jump_sy(599);
        wait_frame(2200, "m0_switch", lsx, lsy, bh);
        check("req0_busy_held", bh, 1);
        check("req0_mode", int'(mode), 0);

        // Mode 0 first line: active-low hs on [-144,-48), 800-cycle line.
        prev_hs = int'(hs);
        rise_sx = 9999; fall_sx = 9999;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
            if (n == 1) check("ack_single_cycle", int'(ack), 0);
            if (prev_hs && !hs && fall_sx == 9999) fall_sx = int'(sx);
            if (!prev_hs && hs && fall_sx != 9999 && rise_sx == 9999) rise_sx = int'(sx);
            prev_hs = int'(hs);
        end while (!line && n < 1000);
        check("m0_hs_fall_sx", fall_sx, -144);
        check("m0_hs_rise_sx", rise_sx, -48);
        check("m0_line_period", n, 800);

        // Switch to mode 3.
        pulse_request(2'd3);
        expect_frame(3, -280, -45, 1, 0);
        jump_sy(479);
        wait_frame(1000, "m3_switch", lsx, lsy, bh);
        check("m3_last_sx", lsx, 639);
        check("m3_last_sy", lsy, 479);
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!line && n < 2500);
        check("m3_line_period", n, 2200);

        // Request on the exact wrap cycle: applies one frame later.
        jump_sy(1079);
        n = 0;
        while (!(int'(sx) == 1919 && int'(sy) == 1079) && n < 2400) begin
            @(posedge clk); #1;
            n++;
        end
        check("wrap_cycle_found", int'(n < 2400), 1);
        expect_frame(3, -280, -45, 0, 1);
        expect_frame(2, -370, -30, 1, 0);
        @(negedge clk);
        valid = 1'b1;
        sel   = 2'd2;
        @(negedge clk);
        valid = 1'b0;
        jump_sy(1079);
        wait_frame(2400, "m2_switch", lsx, lsy, bh);
        check("m2_mode", int'(mode), 2);

        // Re-requesting the current mode still handshakes.
        pulse_request(2'd2);
        expect_frame(2, -370, -30, 1, 0);
        jump_sy(719);
        wait_frame(1700, "m2_same", lsx, lsy, bh);

        // Reset with a request pending: request is dropped.
        pulse_request(2'd0);
        #1;
        check("pend_busy", int'(busy), 1);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst2_mode", int'(mode), 1);
        check("rst2_sx", int'(sx), -256);
        check("rst2_sy", int'(sy), -28);
        check("rst2_busy", int'(busy), 0);
        check("rst2_frame", int'(frame), 0);
        check("rst2_de", int'(de), 0);
        check("rst2_ack", int'(ack), 0);
        expect_frame(1, -256, -28, 0, 0);
        @(negedge clk);
        rst = 1'b0;
        wait_frame(4, "rst2_release", lsx, lsy, bh);
        expect_frame(1, -256, -28, 0, 0);
        jump_sy(599);
        wait_frame(2200, "rst2_wrap", lsx, lsy, bh);

        repeat (3) @(posedge clk);
        #1;
        check("queue_drained", exp_q.size(), 0);
        check("ack_count", ack_seen, 4);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
